// File: rtl/trap_monitor.sv
// trap_monitor: watches the retirement stream and halts on ebreak, an illegal
// opcode, arithmetic overflow or a commit-free watchdog timeout. It keeps a
// small circular history of retired PCs plus cycle and instret counters.
module trap_monitor #(
  parameter int XLEN         = 32,
  parameter int HIST_DEPTH   = 8,
  parameter int WDOG_CYCLES  = 100000,
  parameter bit OVF_TRAP_EN  = 1'b1,
  parameter int FINISH_DELAY = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          commit_valid,
  input  logic [XLEN-1:0]               commit_pc,
  input  logic [31:0]                   commit_insn,
  input  logic [XLEN-1:0]               commit_a0,
  input  logic                          overflow,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_rd_idx,
  output logic [XLEN-1:0]               hist_rd_pc,
  output logic                          halted,
  output logic [2:0]                    halt_cause,
  output logic [XLEN-1:0]               halt_pc,
  output logic [XLEN-1:0]               exit_code,
  output logic [63:0]                   cycle_cnt,
  output logic [63:0]                   instret_cnt
);

  localparam int IDX_W  = $clog2(HIST_DEPTH);
  localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST =
    (WDOG_CYCLES > 0) ? WDOG_W'(WDOG_CYCLES - 1) : '0;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_GOOD    = 3'd1;
  localparam logic [2:0] CAUSE_BAD     = 3'd2;
  localparam logic [2:0] CAUSE_ILLEGAL = 3'd3;
  localparam logic [2:0] CAUSE_WDOG    = 3'd4;
  localparam logic [2:0] CAUSE_OVF     = 3'd5;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic [0:0]        state_q, state_d;
  logic [2:0]        halt_cause_q, halt_cause_d;
  logic [XLEN-1:0]   halt_pc_q, halt_pc_d;
  logic [XLEN-1:0]   exit_code_q, exit_code_d;
  logic [63:0]       cycle_cnt_q, cycle_cnt_d;
  logic [63:0]       instret_cnt_q, instret_cnt_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]    hist_count_q, hist_count_d;
  logic [XLEN-1:0]   last_pc_q, last_pc_d;
  logic [XLEN-1:0]   hist_q [HIST_DEPTH];

  logic             run;
  logic             is_ebreak;
  logic             opcode_legal;
  logic [2:0]       insn_cause;
  logic [2:0]       trap_cause;
  logic             trap;
  logic             hist_we;
  logic [IDX_W-1:0] rd_slot;

  // Classify this cycle's events and pick the winning trap cause by priority
  always_comb begin
    run          = (state_q == ST_RUN);
    is_ebreak    = (commit_insn == EBREAK);
    opcode_legal = 1'b0;
    case (commit_insn[6:0])
      7'h37, 7'h17, 7'h6F, 7'h67, 7'h13, 7'h33,
      7'h03, 7'h23, 7'h63, 7'h0F, 7'h73: opcode_legal = 1'b1;
      default:                           opcode_legal = 1'b0;
    endcase
    insn_cause = CAUSE_NONE;
    if (commit_valid) begin
      if (is_ebreak) begin
        insn_cause = (commit_a0 == '0) ? CAUSE_GOOD : CAUSE_BAD;
      end else if (!opcode_legal) begin
        insn_cause = CAUSE_ILLEGAL;
      end
    end
    trap_cause = CAUSE_NONE;
    if (insn_cause != CAUSE_NONE) begin
      trap_cause = insn_cause;
    end else if (OVF_TRAP_EN && overflow) begin
      trap_cause = CAUSE_OVF;
    end else if ((WDOG_CYCLES != 0) && !commit_valid && (wdog_q == WDOG_LAST)) begin
      trap_cause = CAUSE_WDOG;
    end
    trap = run && (trap_cause != CAUSE_NONE);
  end

  // Next-state for the FSM, counters, watchdog and history bookkeeping
  always_comb begin
    state_d       = state_q;
    halt_cause_d  = halt_cause_q;
    halt_pc_d     = halt_pc_q;
    exit_code_d   = exit_code_q;
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    wdog_d        = wdog_q;
    wr_ptr_d      = wr_ptr_q;
    hist_count_d  = hist_count_q;
    last_pc_d     = last_pc_q;
    hist_we       = 1'b0;
    if (run) begin
      cycle_cnt_d = cycle_cnt_q + 64'd1;
      if (commit_valid) begin
        instret_cnt_d = instret_cnt_q + 64'd1;
        wdog_d        = '0;
        last_pc_d     = commit_pc;
        hist_we       = 1'b1;
        wr_ptr_d      = wr_ptr_q + IDX_W'(1);
        if (hist_count_q != (IDX_W + 1)'(HIST_DEPTH)) begin
          hist_count_d = hist_count_q + (IDX_W + 1)'(1);
        end
      end else begin
        wdog_d = wdog_q + WDOG_W'(1);
      end
      if (trap) begin
        state_d      = ST_HALT;
        halt_cause_d = trap_cause;
        halt_pc_d    = commit_valid ? commit_pc : last_pc_q;
        exit_code_d  = (commit_valid && is_ebreak) ? commit_a0 : '0;
      end
    end
  end

  // Architectural state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      halt_cause_q  <= CAUSE_NONE;
      halt_pc_q     <= '0;
      exit_code_q   <= '0;
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
      wdog_q        <= '0;
      wr_ptr_q      <= '0;
      hist_count_q  <= '0;
      last_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      halt_cause_q  <= halt_cause_d;
      halt_pc_q     <= halt_pc_d;
      exit_code_q   <= exit_code_d;
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
      wdog_q        <= wdog_d;
      wr_ptr_q      <= wr_ptr_d;
      hist_count_q  <= hist_count_d;
      last_pc_q     <= last_pc_d;
    end
  end

  // History storage; contents are not reset because reads are gated by hist_count
  always_ff @(posedge clk) begin
    if (rst && hist_we) begin
      hist_q[wr_ptr_q] <= commit_pc;
    end
  end

  // Newest-first history read; slots not yet written read as zero
  always_comb begin
    rd_slot    = wr_ptr_q - IDX_W'(1) - hist_rd_idx;
    hist_rd_pc = '0;
    if ({1'b0, hist_rd_idx} < hist_count_q) begin
      hist_rd_pc = hist_q[rd_slot];
    end
  end

  assign halted      = (state_q == ST_HALT);
  assign halt_cause  = halt_cause_q;
  assign halt_pc     = halt_pc_q;
  assign exit_code   = exit_code_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;

`ifndef SYNTHESIS
  int   fin_cnt_q;
  logic fin_armed_q;

  // Simulation-only halt report, progress messages and delayed end of run
  always_ff @(posedge clk) begin
    if (!rst) begin
      fin_armed_q <= 1'b0;
      fin_cnt_q   <= 0;
    end else begin
      if (trap) begin
        $display("[trap_monitor] halt: cause=%0d pc=0x%h exit_code=0x%h",
                 trap_cause, halt_pc_d, exit_code_d);
        fin_armed_q <= (FINISH_DELAY != 0);
        fin_cnt_q   <= 0;
      end else if (fin_armed_q) begin
        if (fin_cnt_q == FINISH_DELAY - 1) begin
          fin_armed_q <= 1'b0;
          if (halt_cause_q == CAUSE_GOOD) $finish(0);
          else $finish(1);
        end else begin
          fin_cnt_q <= fin_cnt_q + 1;
        end
      end
      if (run && commit_valid && ((instret_cnt_d % 64'd10000) == 64'd0)) begin
        $display("[trap_monitor] cycle=%0d pc=0x%h", cycle_cnt_d, commit_pc);
      end
    end
  end
`endif

endmodule

// File: doc/trap_monitor.md
TRAP_MONITOR -- requirements
Module: trap_monitor

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the width of the PC and exit code.
REQ-002 SHALL have parameter HIST_DEPTH, default 8, meaning the PC history depth (power of 2, ≥2).
REQ-003 SHALL have parameter WDOG_CYCLES, default 100000, meaning the number of commit-free cycles before a watchdog trap (0 = disabled).
REQ-004 SHALL have parameter OVF_TRAP_EN, default 1, meaning overflow raises a trap.
REQ-005 SHALL have parameter FINISH_DELAY, default 2, meaning cycles spent in HALT before the simulation-only $finish (0 = never call $finish).
REQ-006 SHALL have port clk, input, 1 bit: clock.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-008 SHALL have port commit_valid, input, 1 bit: one instruction retires this cycle.
REQ-009 SHALL have port commit_pc, input, XLEN bits: PC of the retiring instruction.
REQ-010 SHALL have port commit_insn, input, 32 bits: encoding of the retiring instruction.
REQ-011 SHALL have port commit_a0, input, XLEN bits: value of x10 at retire.
REQ-012 SHALL have port overflow, input, 1 bit: arithmetic overflow flag.
REQ-013 SHALL have port hist_rd_idx, input, log2(HIST_DEPTH) bits: history read index (0 = newest).
REQ-014 SHALL have port hist_rd_pc, output, XLEN bits: PC at hist_rd_idx.
REQ-015 SHALL have port halted, output, 1 bit: the FSM is in HALT.
REQ-016 SHALL have port halt_cause, output, 3 bits: trap cause code.
REQ-017 SHALL have port halt_pc, output, XLEN bits: PC at the trap.
REQ-018 SHALL have port exit_code, output, XLEN bits: latched commit_a0 for ebreak traps, else 0.
REQ-019 SHALL have port cycle_cnt, output, 64 bits: cycles spent in RUN.
REQ-020 SHALL have port instret_cnt, output, 64 bits: committed instructions.

Function
REQ-021 SHALL implement the states RUN and HALT, with the transition RUN→HALT on a trap event and HALT→RUN only on reset.
REQ-022 SHALL encode halt_cause as: 0 none; 1 GOOD (ebreak 0x00100073, commit_a0==0); 2 BAD_EXIT (ebreak, a0≠0); 3 ILLEGAL (opcode not in {LUI, AUIPC, JAL, JALR, OP-IMM, OP, LOAD, STORE, BRANCH, MISC-MEM, SYSTEM}); 4 WATCHDOG; 5 OVERFLOW.
REQ-023 SHALL evaluate commit_insn only when commit_valid=1, and overflow only when OVF_TRAP_EN=1.
REQ-024 SHALL resolve same-cycle events by priority: instruction cause (1/2/3) > OVERFLOW > WATCHDOG.
REQ-025 SHALL, on a trap cycle, register halted=1, halt_cause, halt_pc and exit_code at the next edge; for OVERFLOW/WATCHDOG, halt_pc = the last committed PC (0 if none).
REQ-026 SHALL keep a watchdog counter that clears on commit_valid, otherwise increments in RUN, and fires when it reaches WDOG_CYCLES-1 with no commit that cycle.
REQ-027 SHALL, in RUN, increment cycle_cnt every cycle, including the trap cycle.
REQ-028 SHALL, in RUN, increment instret_cnt per commit_valid, including the trapping instruction.
REQ-029 SHALL freeze cycle_cnt and instret_cnt in HALT.
REQ-030 SHALL make the history a circular buffer: each RUN commit writes commit_pc at wr_ptr, wr_ptr wraps modulo HIST_DEPTH, and hist_count saturates at HIST_DEPTH.
REQ-031 SHALL drive hist_rd_pc combinationally as buf[(wr_ptr-1-idx) mod HIST_DEPTH] when idx<hist_count, else 0.
REQ-032 SHALL ignore all inputs except hist_rd_idx in HALT.
REQ-033 SHALL keep the history readable in HALT.
REQ-034 SHALL (simulation only), on entering HALT, $display the cause, PC and exit code once, and call $finish(0) for cause 1, $finish(1) otherwise, FINISH_DELAY cycles later.
REQ-035 SHALL (simulation only) $display cycle_cnt and PC every 10000 commits.

Reset
REQ-036 SHALL, when rst=0 at a clk edge, set state=RUN, halted=0, halt_cause=0, halt_pc=0, exit_code=0, cycle_cnt=0, instret_cnt=0, watchdog=0, wr_ptr=0, hist_count=0, with history contents don't-care but reading as 0.
REQ-037 SHALL, on reset asserted mid-run or in HALT, abort any pending $finish countdown.

Verification
REQ-038 SHALL verify: commits at PCs 0x80000000, +4, +8, then 0x00100073 with a0=0 → halted=1, cause=1, halt_pc=0x8000000C, instret=4, $finish(0).
REQ-039 SHALL verify: ebreak with a0=0x2A → cause=2, exit_code=0x2A, $finish(1).
REQ-040 SHALL verify: insn 0x0000007F at 0x80000010 → cause=3, halt_pc=0x80000010; a further commit in HALT leaves the counters unchanged.
REQ-041 SHALL verify: WDOG_CYCLES=16 with no commits after PC 0x80000020 → halt after the 16th idle cycle, cause=4, halt_pc=0x80000020.
REQ-042 SHALL verify: overflow=1 together with a legal commit → cause=5; overflow together with an illegal commit → cause=3.
REQ-043 SHALL verify: 11 commits with HIST_DEPTH=8 → idx0 returns the newest PC, idx7 the 4th PC; 3 commits → idx3 returns 0.
REQ-044 SHALL verify: rst=0 for one cycle while in HALT → all outputs return to 0 and RUN resumes.
